// File: rtl/ram_arbiter.sv
// Arbiter sharing one single-ported RAM between the fetch port and the data port.
// One transaction in flight at a time; data wins unless fetch has been starved too long.
module ram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_ack,
  output logic              bus_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic              berr_q, berr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic dreq;
  logic starveHit;
  logic tmoHit;
  logic ackI;
  logic ackD;

  assign dreq      = dREN | dWEN;
  assign starveHit = iREN && (starve_q == SW'(STARVE_MAX));
  assign tmoHit    = (tmo_q == TW'(TIMEOUT - 1));
  assign ackI      = (state_q == IBUSY) && ram_ack;
  assign ackD      = (state_q == DBUSY) && ram_ack;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      berr_q   <= 1'b0;
      starve_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      berr_q   <= berr_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ren_d    = ren_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    store_d  = store_q;
    berr_d   = berr_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (dreq && !starveHit) begin
          // A simultaneous read+write request is served as a write.
          state_d = DBUSY;
          addr_d  = daddr;
          wen_d   = dWEN;
          ren_d   = ~dWEN;
          store_d = dWEN ? dstore : '0;
          tmo_d   = '0;
          if (!iREN) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (iREN) begin
          state_d  = IBUSY;
          addr_d   = iaddr;
          ren_d    = 1'b1;
          wen_d    = 1'b0;
          store_d  = '0;
          tmo_d    = '0;
          starve_d = '0;
        end
      end
      IBUSY, DBUSY: begin
        // An ack arriving on the timeout cycle completes normally.
        if (ram_ack) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          tmo_d   = '0;
        end else if (tmoHit) begin
          state_d = IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          berr_d  = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  assign iwait     = iREN & ~ackI;
  assign dwait     = dreq & ~ackD;
  assign iload     = ackI ? ram_load : '0;
  assign dload     = (ackD && !wen_q) ? ram_load : '0;
  assign ram_ren   = ren_q;
  assign ram_wen   = wen_q;
  assign ram_addr  = addr_q;
  assign ram_store = store_q;
  assign bus_err   = berr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: fetch/data arbitration, starvation, writes, timeout, reset and flush.
module tb_ram_arbiter;

  logic        clock;
  logic        reset;
  logic        iRen;
  logic [31:0] iAddr;
  logic        iWait;
  logic [31:0] iLoad;
  logic        dRen;
  logic        dWen;
  logic [31:0] dAddr;
  logic [31:0] dStore;
  logic        dWait;
  logic [31:0] dLoad;
  logic        ramRen;
  logic        ramWen;
  logic [31:0] ramAddr;
  logic [31:0] ramStore;
  logic [31:0] ramLoad;
  logic        ramAck;
  logic        busErr;

  int checkCount;
  int errorCount;

  ram_arbiter #(
    .ADDR_W(32),
    .WORD_W(32),
    .STARVE_MAX(4),
    .TIMEOUT(8)
  ) dut (
    .CLK(clock),
    .RST(reset),
    .iREN(iRen),
    .iaddr(iAddr),
    .iwait(iWait),
    .iload(iLoad),
    .dREN(dRen),
    .dWEN(dWen),
    .daddr(dAddr),
    .dstore(dStore),
    .dwait(dWait),
    .dload(dLoad),
    .ram_ren(ramRen),
    .ram_wen(ramWen),
    .ram_addr(ramAddr),
    .ram_store(ramStore),
    .ram_load(ramLoad),
    .ram_ack(ramAck),
    .bus_err(busErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                               input logic [31:0] da, input logic [31:0] ds,
                               input logic ack, input logic [31:0] ld);
    iRen    = ir;
    iAddr   = ia;
    dRen    = dr;
    dWen    = dw;
    dAddr   = da;
    dStore  = ds;
    ramAck  = ack;
    ramLoad = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit isFetch [10];
    logic [31:0] expAddr;
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_ren", ramRen, 0);
    checkOutput("rst_wen", ramWen, 0);
    checkOutput("rst_addr", ramAddr, 0);
    checkOutput("rst_store", ramStore, 0);
    checkOutput("rst_berr", busErr, 0);
    checkOutput("rst_iwait", iWait, 0);
    reset = 1'b0;

    // Single fetch, ack three cycles after the strobe rises
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 0, 0);
    checkOutput("f1_iwait_req", iWait, 1);
    checkOutput("f1_ren_req", ramRen, 0);
    tick();
    checkOutput("f1_ren", ramRen, 1);
    checkOutput("f1_addr", ramAddr, 32'h40);
    checkOutput("f1_iwait_busy", iWait, 1);
    tick();
    tick();
    checkOutput("f1_ren_hold", ramRen, 1);
    tick();
    applyStimulus(1, 32'h40, 0, 0, 0, 0, 1, 32'h2108000A);
    checkOutput("f1_iwait_ack", iWait, 0);
    checkOutput("f1_iload", iLoad, 32'h2108000A);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h2108000A);
    checkOutput("f1_ren_idle", ramRen, 0);
    checkOutput("f1_iload_idle", iLoad, 0);

    // Fetch and data together: data first, bubble, then fetch
    applyStimulus(1, 32'h44, 1, 0, 32'h100, 32'h9, 0, 0);
    tick();
    checkOutput("c_addr_d", ramAddr, 32'h100);
    checkOutput("c_ren_d", ramRen, 1);
    checkOutput("c_store_d", ramStore, 0);
    applyStimulus(1, 32'h44, 1, 0, 32'h100, 32'h9, 1, 32'h55);
    checkOutput("c_dwait_ack", dWait, 0);
    checkOutput("c_dload", dLoad, 32'h55);
    checkOutput("c_iwait_ack", iWait, 1);
    checkOutput("c_iload_0", iLoad, 0);
    tick();
    applyStimulus(1, 32'h44, 0, 0, 0, 0, 0, 0);
    checkOutput("c_bubble_ren", ramRen, 0);
    tick();
    checkOutput("c_addr_i", ramAddr, 32'h44);
    checkOutput("c_ren_i", ramRen, 1);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, 1, 32'h77);
    checkOutput("c_iload", iLoad, 32'h77);
    checkOutput("c_iwait_rel", iWait, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Starvation: fetch held, data continuous
    isFetch = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1, 32'h48, 1, 0, 32'h200 + 4 * k, 0, 0, 0);
      tick();
      expAddr = isFetch[k] ? 32'h48 : 32'h200 + 4 * k;
      checkOutput($sformatf("st_addr%0d", k), ramAddr, expAddr);
      applyStimulus(1, 32'h48, 1, 0, 32'h200 + 4 * k, 0, 1, k);
      checkOutput($sformatf("st_iwait%0d", k), iWait, isFetch[k] ? 0 : 1);
      checkOutput($sformatf("st_dwait%0d", k), dWait, isFetch[k] ? 1 : 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Read+write together is a write; then a plain read clears store data
    applyStimulus(0, 0, 1, 1, 32'h80, 32'hDEADBEEF, 0, 0);
    tick();
    checkOutput("w_wen", ramWen, 1);
    checkOutput("w_ren", ramRen, 0);
    checkOutput("w_store", ramStore, 32'hDEADBEEF);
    checkOutput("w_addr", ramAddr, 32'h80);
    applyStimulus(0, 0, 1, 1, 32'h80, 32'hDEADBEEF, 1, 32'h1234);
    checkOutput("w_dload", dLoad, 0);
    checkOutput("w_dwait", dWait, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'h84, 32'hFFFF, 0, 0);
    tick();
    checkOutput("r_store", ramStore, 0);
    checkOutput("r_wen", ramWen, 0);
    checkOutput("r_ren", ramRen, 1);
    applyStimulus(0, 0, 1, 0, 32'h84, 32'hFFFF, 1, 32'h4321);
    checkOutput("r_dload", dLoad, 32'h4321);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Ack on the timeout cycle wins
    applyStimulus(0, 0, 1, 0, 32'h300, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) tick();
    applyStimulus(0, 0, 1, 0, 32'h300, 0, 1, 32'h11);
    checkOutput("ta_dwait", dWait, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ta_berr", busErr, 0);
    checkOutput("ta_ren", ramRen, 0);

    // Missing ack: abort after 8 busy cycles, then retry
    applyStimulus(0, 0, 1, 0, 32'h304, 0, 0, 0);
    tick();
    for (int i = 0; i < 7; i++) tick();
    checkOutput("to_ren_c8", ramRen, 1);
    checkOutput("to_berr_c8", busErr, 0);
    tick();
    checkOutput("to_ren_drop", ramRen, 0);
    checkOutput("to_berr_set", busErr, 1);
    checkOutput("to_dwait", dWait, 1);
    tick();
    checkOutput("to_regrant", ramRen, 1);
    checkOutput("to_readdr", ramAddr, 32'h304);
    applyStimulus(0, 0, 1, 0, 32'h304, 0, 1, 32'hCAFEF00D);
    checkOutput("to_dload", dLoad, 32'hCAFEF00D);
    checkOutput("to_dwait_ack", dWait, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("to_berr_sticky", busErr, 1);
    checkOutput("to_ren_idle", ramRen, 0);

    // Reset in the middle of a data write
    applyStimulus(0, 0, 1, 1, 32'h90, 32'hABCD, 0, 0);
    tick();
    checkOutput("rm_wen", ramWen, 1);
    reset = 1'b1;
    #1;
    checkOutput("rm_wen0", ramWen, 0);
    checkOutput("rm_addr0", ramAddr, 0);
    checkOutput("rm_store0", ramStore, 0);
    checkOutput("rm_berr0", busErr, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Fetch withdrawn during IBUSY: ack consumed silently
    tick();
    applyStimulus(1, 32'h60, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("fl_ren", ramRen, 1);
    checkOutput("fl_addr", ramAddr, 32'h60);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("fl_iwait_wd", iWait, 0);
    tick();
    checkOutput("fl_ren_hold", ramRen, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h99);
    checkOutput("fl_iwait_ack", iWait, 0);
    checkOutput("fl_dwait_ack", dWait, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 32'hA0, 0, 0, 0);
    checkOutput("fl_ren_idle", ramRen, 0);
    tick();
    checkOutput("fl_next_addr", ramAddr, 32'hA0);
    checkOutput("fl_next_ren", ramRen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-ported unified RAM between the pipeline's instruction-fetch port and data-memory port.
- Holds one outstanding RAM transaction at a time.
- Data accesses (LW/SW) win by default; a starvation counter forces an instruction grant after a bounded run of data grants.
- A watchdog reports a RAM that never acknowledges.
- Sits between the fetch/MEM stages and the RAM model, in place of direct port wiring.

Parameters:
- ADDR_W, 32, address width in bits.
- WORD_W, 32, data word width in bits.
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before fetch is forced (must be ≥1).
- TIMEOUT, 255, busy cycles without ram_ack before abort (must be ≥2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  fetch read request; held until iwait low.
- iaddr  in  ADDR_W  fetch address.
- iwait  out  1  fetch stall.
- iload  out  WORD_W  fetched word.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  WORD_W  store data.
- dwait  out  1  data stall.
- dload  out  WORD_W  loaded word.
- ram_ren  out  1  RAM read strobe, registered.
- ram_wen  out  1  RAM write strobe, registered.
- ram_addr  out  ADDR_W  RAM address, registered.
- ram_store  out  WORD_W  RAM write data, registered.
- ram_load  in  WORD_W  RAM read data, valid with ram_ack.
- ram_ack  in  1  one-cycle completion pulse from RAM.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, immediate): state IDLE; ram_ren=0, ram_wen=0, ram_addr=0, ram_store=0; bus_err=0; starve_cnt=0; tmo_cnt=0. An in-flight transaction is dropped, with no ack forwarded.
- States:
  - IDLE: no outstanding transaction; RAM strobes 0.
  - IBUSY: fetch read outstanding.
  - DBUSY: data read or write outstanding.
- Arbitration happens only in IDLE, evaluated each cycle on current inputs:
  - dreq = dREN|dWEN.
  - If dreq and not (iREN and starve_cnt==STARVE_MAX): go to DBUSY.
  - Else if iREN: go to IBUSY.
  - Else stay in IDLE.
- Grant register loads on the transition edge: ram_addr, ram_ren/ram_wen, ram_store. Strobes are high from cycle N+1 (request seen in cycle N) until the ack cycle inclusive, then return to 0.
- dREN and dWEN both high: treated as a write (ram_wen=1, ram_ren=0).
- ram_store = dstore for writes; 0 for reads.
- Completion: in a busy state, ram_ack=1 returns the block to IDLE on the next edge. There is always one IDLE bubble between transactions, so minimum request-to-release latency is 2 cycles (ack in N+1).
- iwait = iREN & ~(state==IBUSY & ram_ack).
- dwait = dreq & ~(state==DBUSY & ram_ack).
- Both wait signals are combinational. The released port's wait is low for exactly the ack cycle.
- iload = ram_load when state==IBUSY & ram_ack, else 0. dload likewise for DBUSY reads.
- Request withdrawn mid-transaction (flush): the RAM transaction still completes. The ack is consumed, no wait is affected, and the block returns to IDLE.
- ram_ack in IDLE: ignored.
- starve_cnt is updated on grants only:
  - Data grant with iREN high: increment, saturating at STARVE_MAX.
  - Instruction grant: clear to 0.
  - Data grant with iREN low: clear to 0.
- Watchdog:
  - tmo_cnt clears on entry to a busy state and increments each busy cycle without ack.
  - When tmo_cnt reaches TIMEOUT-1 with no ack: go to IDLE, drop strobes, set bus_err=1 (sticky until RST), clear tmo_cnt.
  - Requesters still see wait high; the request re-arbitrates normally.
- Ack on the same cycle as timeout: the ack wins and no error is raised.
- Widths: tmo_cnt is $clog2(TIMEOUT+1) bits. starve_cnt is $clog2(STARVE_MAX+1) bits.

Test Plan:
- Reset, then iREN=1, iaddr=0x40, ram_ack 3 cycles after ram_ren rises, ram_load=0x2108000A -> ram_ren/ram_addr=0x40 one cycle after request; iwait low only in ack cycle with iload=0x2108000A; IDLE next cycle.
- iREN=1 and dREN=1 (daddr=0x100) asserted together -> data granted first; dwait drops on its ack; one IDLE bubble; fetch then granted.
- iREN held high, data requests continuous, STARVE_MAX=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes; starve_cnt back to 0 after the fetch grant.
- dREN=1 and dWEN=1, daddr=0x80, dstore=0xDEADBEEF -> ram_wen=1, ram_ren=0, ram_store=0xDEADBEEF; dload=0 on ack.
- ram_ack never arrives, TIMEOUT=8 -> strobes drop after 8 busy cycles; bus_err=1 and stays set; request re-granted next IDLE; a later ack completes the transfer normally.
- RST asserted mid-DBUSY, then iREN withdrawn during IBUSY -> all registered outputs 0 immediately on RST; the withdrawn fetch's ack produces no wait change and returns the block to IDLE.
